// File: rtl/gb_sound_pkg.sv
`default_nettype none
// ============================================================================
// Module : gb_sound_pkg
// Brief  : Shared constants, duty encodings and duty lookup for sound channels.
// Rev    : 1.0
// ============================================================================
package gb_sound_pkg;

    localparam int TIMER_BASE = 2048;
    localparam int LENGTH_MAX = 64;

    typedef enum logic [1:0] {
        DUTY_12 = 2'b00,
        DUTY_25 = 2'b01,
        DUTY_50 = 2'b10,
        DUTY_75 = 2'b11
    } duty_e;

    // Bit i of each row is the output level during duty step i.
    localparam logic [3:0][7:0] DUTY_TABLE = {
        8'b0111_1110,   // 75%
        8'b1110_0001,   // 50%
        8'b1000_0001,   // 25%
        8'b1000_0000    // 12.5%
    };

    function automatic logic duty_bit(input logic [1:0] duty, input logic [2:0] step);
        return DUTY_TABLE[duty][step];
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_channel_if.sv
`default_nettype none
// ============================================================================
// Module : pulse_channel_if
// Brief  : Control and sample bundle between upstream sequencer and pulse channel.
// Rev    : 1.0
// ============================================================================
interface pulse_channel_if #(
    parameter int FREQ_WIDTH   = 11,
    parameter int LENGTH_WIDTH = 6,
    parameter int VOL_WIDTH    = 4
);
    logic                    trigger;
    logic [FREQ_WIDTH-1:0]   frequency;
    logic [1:0]              duty;
    logic [LENGTH_WIDTH-1:0] length_load;
    logic                    length_enable;
    logic                    tick_256;
    logic                    dac_enable;
    logic [VOL_WIDTH-1:0]    volume;
    logic [VOL_WIDTH-1:0]    sample;
    logic                    active;

    modport master (
        output trigger, frequency, duty, length_load, length_enable,
        output tick_256, dac_enable, volume,
        input  sample, active
    );

    modport slave (
        input  trigger, frequency, duty, length_load, length_enable,
        input  tick_256, dac_enable, volume,
        output sample, active
    );
endinterface
`default_nettype wire

// File: rtl/channel_length_counter.sv
`default_nettype none
// ============================================================================
// Module : channel_length_counter
// Brief  : Note length counter; strobes o_expired on the tick that reaches zero.
// Rev    : 1.0
// ============================================================================
module channel_length_counter #(
    parameter int LENGTH_WIDTH = 6
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    i_trigger,
    input  wire logic                    i_tick,
    input  wire logic                    i_enable,
    input  wire logic [LENGTH_WIDTH-1:0] i_load,
    output      logic                    o_expired
);
    localparam logic [LENGTH_WIDTH:0] c_len_max = {1'b1, {LENGTH_WIDTH{1'b0}}};
    localparam logic [LENGTH_WIDTH:0] c_one     = {{LENGTH_WIDTH{1'b0}}, 1'b1};

    logic [LENGTH_WIDTH:0] r_count;
    logic                  w_dec;

    // Trigger takes priority over a coincident tick.
    assign w_dec     = i_tick && i_enable && (r_count != '0) && !i_trigger;
    assign o_expired = w_dec && (r_count == c_one);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_trigger) begin
            r_count <= c_len_max - {1'b0, i_load};
        end else if (w_dec) begin
            r_count <= r_count - c_one;
        end
    end
endmodule
`default_nettype wire

// File: rtl/pulse_channel.sv
`default_nettype none
// ============================================================================
// Module : pulse_channel
// Brief  : Square-wave pulse channel: frequency timer, 8-step duty, length stop.
// Rev    : 1.0
// ============================================================================
module pulse_channel
    import gb_sound_pkg::*;
#(
    parameter int FREQ_WIDTH   = 11,
    parameter int LENGTH_WIDTH = 6,
    parameter int VOL_WIDTH    = 4
) (
    input wire logic       clk,
    input wire logic       reset,
    pulse_channel_if.slave bus
);
    localparam logic [FREQ_WIDTH:0] c_timer_base = {1'b1, {FREQ_WIDTH{1'b0}}};
    localparam logic [FREQ_WIDTH:0] c_one        = {{FREQ_WIDTH{1'b0}}, 1'b1};

    logic [FREQ_WIDTH:0]  r_timer;
    logic [2:0]           r_step;
    logic                 r_active;
    logic [VOL_WIDTH-1:0] r_sample;

    logic [FREQ_WIDTH:0]  w_reload;
    logic                 w_duty_bit;
    logic                 w_expired;

    // Frequency 0 yields the full-width base period.
    assign w_reload   = c_timer_base - {1'b0, bus.frequency};
    assign w_duty_bit = duty_bit(bus.duty, r_step);

    channel_length_counter #(
        .LENGTH_WIDTH (LENGTH_WIDTH)
    ) u_length (
        .clk       (clk),
        .rst       (reset),
        .i_trigger (bus.trigger),
        .i_tick    (bus.tick_256),
        .i_enable  (bus.length_enable),
        .i_load    (bus.length_load),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer  <= '0;
            r_step   <= '0;
            r_active <= 1'b0;
            r_sample <= '0;
        end else begin
            r_sample <= (r_active && w_duty_bit) ? bus.volume : '0;
            if (bus.trigger) begin
                r_timer  <= w_reload;
                r_step   <= '0;
                r_active <= bus.dac_enable;
            end else begin
                if (r_active) begin
                    if (r_timer <= c_one) begin
                        r_timer <= w_reload;
                        r_step  <= r_step + 3'd1;
                    end else begin
                        r_timer <= r_timer - c_one;
                    end
                end
                if (!bus.dac_enable || w_expired) begin
                    r_active <= 1'b0;
                end
            end
        end
    end

    assign bus.sample = r_sample;
    assign bus.active = r_active;
endmodule
`default_nettype wire
